// File: rtl/datapath_controller.sv
// Instruction sequencer for the 16-bit register/ALU datapath.
// It latches one instruction per start/ready handshake into the IR. A Moore FSM then
// walks that instruction through decode, register read, execute and write-back.
// Every strobe is decoded from the state and IR registers only.
module datapath_controller #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned SIZE       = 8,
    // The register fields in the instruction are 3 bits wide, so this must stay at 3.
    localparam int unsigned ADDR_WIDTH = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s,
    input  logic [15:0]           instr,
    output logic                  w,
    output logic                  illegal,
    output logic [1:0]            vsel,
    output logic [ADDR_WIDTH-1:0] writenum,
    output logic [ADDR_WIDTH-1:0] readnum1,
    output logic [ADDR_WIDTH-1:0] readnum2,
    output logic                  write,
    output logic                  loada,
    output logic                  loadb,
    output logic                  loadc,
    output logic                  loads,
    output logic                  asel,
    output logic                  bsel,
    output logic [1:0]            shift,
    output logic [1:0]            aluop,
    output logic [WIDTH-1:0]      sximm5,
    output logic [WIDTH-1:0]      sximm8
);

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StWimm,
        StRead,
        StExec,
        StWb
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    // IR field views
    logic [2:0]            op3;
    logic [1:0]            op;
    logic [ADDR_WIDTH-1:0] rn, rd, rm;
    logic [1:0]            sh;

    assign op3 = ir_q[15:13];
    assign op  = ir_q[12:11];
    assign rn  = ir_q[10:8];
    assign rd  = ir_q[7:5];
    assign sh  = ir_q[4:3];
    assign rm  = ir_q[2:0];

    logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_legal;

    assign is_mov_imm = (op3 == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (op3 == 3'b110) && (op == 2'b00);
    assign is_alu     = (op3 == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_legal   = is_mov_imm || is_mov_reg || is_alu;

    assign sximm5 = {{(WIDTH - 5){ir_q[4]}}, ir_q[4:0]};
    assign sximm8 = {{(WIDTH - 8){ir_q[7]}}, ir_q[7:0]};

    // Next-state and IR capture; s and instr matter only while idle.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            StIdle: begin
                if (s) begin
                    ir_d    = instr;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (is_mov_imm) begin
                    state_d = StWimm;
                end else if (is_legal) begin
                    state_d = StRead;
                end else begin
                    state_d = StIdle;
                end
            end
            StWimm:  state_d = StIdle;
            StRead:  state_d = StExec;
            StExec:  state_d = is_cmp ? StIdle : StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and IR registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Moore strobe decode: each state drives only its own strobes, everything else is 0.
    always_comb begin
        w        = 1'b0;
        illegal  = 1'b0;
        vsel     = 2'b00;
        writenum = '0;
        readnum1 = '0;
        readnum2 = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        aluop    = 2'b00;
        unique case (state_q)
            StIdle: begin
                w = 1'b1;
            end
            StDecode: begin
                illegal = !is_legal;
            end
            StWimm: begin
                vsel     = 2'b01;
                writenum = rn;
                write    = 1'b1;
            end
            StRead: begin
                readnum1 = rn;
                readnum2 = rm;
                loada    = 1'b1;
                loadb    = 1'b1;
            end
            StExec: begin
                bsel  = 1'b1;
                shift = sh;
                // MOV reg passes the shifted B operand straight through the ALU.
                asel  = !is_mov_reg;
                aluop = is_mov_reg ? 2'b00 : op;
                loads = is_cmp;
                loadc = !is_cmp;
            end
            StWb: begin
                vsel     = 2'b00;
                writenum = rd;
                write    = 1'b1;
            end
            default: begin
                w = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_datapath_controller.sv
// Self-checking bench for datapath_controller. A per-instruction reference model
// expands each instruction into the list of strobe sets expected on successive cycles.
module tb_datapath_controller;

    localparam int unsigned WIDTH = 16;

    logic        clk;
    logic        reset_n;
    logic        s;
    logic [15:0] instr;
    logic        w, illegal, write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  vsel, shift, aluop;
    logic [2:0]  writenum, readnum1, readnum2;
    logic [WIDTH-1:0] sximm5, sximm8;

    datapath_controller #(
        .WIDTH (WIDTH),
        .SIZE  (8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s        (s),
        .instr    (instr),
        .w        (w),
        .illegal  (illegal),
        .vsel     (vsel),
        .writenum (writenum),
        .readnum1 (readnum1),
        .readnum2 (readnum2),
        .write    (write),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .aluop    (aluop),
        .sximm5   (sximm5),
        .sximm8   (sximm8)
    );

    typedef struct packed {
        logic       w;
        logic       illegal;
        logic [1:0] vsel;
        logic [2:0] writenum;
        logic [2:0] readnum1;
        logic [2:0] readnum2;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
    } ctl_t;

    ctl_t got;
    assign got = {w, illegal, vsel, writenum, readnum1, readnum2, write,
                  loada, loadb, loadc, loads, asel, bsel, shift, aluop};

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_ir;
    ctl_t        exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t idle_vec();
        ctl_t c;
        c   = '0;
        c.w = 1'b1;
        return c;
    endfunction

    // Reference model: the cycle-by-cycle strobe sets one instruction produces.
    function automatic void build(input logic [15:0] ins);
        logic [2:0] op3, rn, rd, rm;
        logic [1:0] op, sh;
        bit         mov_imm, mov_reg, alu, cmp;
        ctl_t       c;
        op3     = ins[15:13];
        op      = ins[12:11];
        rn      = ins[10:8];
        rd      = ins[7:5];
        sh      = ins[4:3];
        rm      = ins[2:0];
        mov_imm = (op3 == 3'b110) && (op == 2'b10);
        mov_reg = (op3 == 3'b110) && (op == 2'b00);
        alu     = (op3 == 3'b101);
        cmp     = alu && (op == 2'b01);
        exp_q.delete();
        // decode cycle
        c         = '0;
        c.illegal = !(mov_imm || mov_reg || alu);
        exp_q.push_back(c);
        if (mov_imm) begin
            c          = '0;
            c.vsel     = 2'd1;
            c.writenum = rn;
            c.write    = 1'b1;
            exp_q.push_back(c);
        end else if (mov_reg || alu) begin
            c          = '0;
            c.readnum1 = rn;
            c.readnum2 = rm;
            c.loada    = 1'b1;
            c.loadb    = 1'b1;
            exp_q.push_back(c);
            c       = '0;
            c.bsel  = 1'b1;
            c.shift = sh;
            c.asel  = mov_reg ? 1'b0 : 1'b1;
            c.aluop = mov_reg ? 2'b00 : op;
            c.loads = cmp;
            c.loadc = !cmp;
            exp_q.push_back(c);
            if (!cmp) begin
                c          = '0;
                c.writenum = rd;
                c.write    = 1'b1;
                exp_q.push_back(c);
            end
        end
    endfunction

    task automatic check_ctl(input string tag, input ctl_t e);
        logic signed [7:0]  i8;
        logic signed [4:0]  i5;
        logic signed [15:0] e8;
        logic signed [15:0] e5;
        i8 = model_ir[7:0];
        i5 = model_ir[4:0];
        e8 = i8;
        e5 = i5;
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s ctl: observed=%h expected=%h", tag, got, e);
        end
        checks++;
        assert (sximm8 === e8) else begin
            errors++;
            $error("FAIL %s sximm8: observed=%h expected=%h", tag, sximm8, e8);
        end
        checks++;
        assert (sximm5 === e5) else begin
            errors++;
            $error("FAIL %s sximm5: observed=%h expected=%h", tag, sximm5, e5);
        end
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge where it is idle again.
    task automatic run(input logic [15:0] ins, input bit toggle, input string tag);
        s        = 1'b1;
        instr    = ins;
        model_ir = ins;
        build(ins);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            check_ctl(tag, exp_q.pop_front());
            if (toggle) begin
                s     = 1'($urandom);
                instr = 16'($urandom);
            end else begin
                s = 1'b0;
            end
        end
        @(negedge clk);
        s = 1'b0;
        check_ctl({tag, "/done"}, idle_vec());
    endtask

    initial begin
        logic [15:0] ins;
        logic [2:0]  op3;
        reset_n  = 1'b1;
        s        = 1'b0;
        instr    = 16'h0;
        model_ir = 16'h0;

        // asynchronous reset asserted mid-cycle
        #7 reset_n = 1'b0;
        #1 check_ctl("reset_async", idle_vec());
        @(negedge clk);
        check_ctl("reset_held", idle_vec());
        reset_n = 1'b1;

        repeat (10) begin
            @(negedge clk);
            check_ctl("idle_s0", idle_vec());
        end

        run(16'hD007, 1'b0, "mov_imm7");
        run(16'hD1FE, 1'b0, "mov_immneg");
        run(16'hA148, 1'b0, "add_lsl1");
        run(16'hA801, 1'b0, "cmp");
        run(16'hB860, 1'b0, "mvn");
        run(16'hC080, 1'b0, "mov_reg");
        run(16'h0000, 1'b0, "illegal0");
        run(16'hC800, 1'b0, "illegalC8");
        run(16'hA148, 1'b1, "add_toggle");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       op3 = 3'b101;
                1:       op3 = 3'b110;
                default: op3 = 3'($urandom);
            endcase
            ins = {op3, 13'($urandom)};
            run(ins, 1'($urandom), "random");
        end

        // reset during EXEC of an ADD: loadc must drop at once and no WB follows
        s        = 1'b1;
        instr    = 16'hA148;
        model_ir = 16'hA148;
        build(16'hA148);
        @(negedge clk);
        check_ctl("rst_decode", exp_q.pop_front());
        s = 1'b0;
        @(negedge clk);
        check_ctl("rst_read", exp_q.pop_front());
        @(negedge clk);
        check_ctl("rst_exec", exp_q.pop_front());
        exp_q.delete();
        #2 reset_n = 1'b0;
        model_ir = 16'h0;
        #1 check_ctl("rst_in_exec", idle_vec());
        @(negedge clk);
        check_ctl("rst_in_exec_held", idle_vec());
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_ctl("rst_release", idle_vec());
        end
        run(16'hD37F, 1'b0, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
